// File: rtl/prga.sv
// RC4 pseudo-random generation stage: walks the KSA-scrambled S array, XORs the
// keystream onto a length-prefixed ciphertext and writes the length-prefixed plaintext.
module prga (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    typedef enum logic [3:0] {
        IDLE, RDL, CAPL, RDI, CAPI, CAPJ, WRJ, RDP, CAPP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] k_q, k_d;
    logic [7:0] len_q, len_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] ctb_q, ctb_d;
    logic [7:0] j_sum;

    // j advances by S[i]; the same wrapped sum addresses S[j] in CAPI
    assign j_sum = j_q + s_rddata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd0;
            len_q   <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            ctb_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            ctb_q   <= ctb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RDL;
            RDL:     state_d = CAPL;
            CAPL:    state_d = (ct_rddata == 8'd0) ? IDLE : RDI;
            RDI:     state_d = CAPI;
            CAPI:    state_d = CAPJ;
            CAPJ:    state_d = WRJ;
            WRJ:     state_d = RDP;
            RDP:     state_d = CAPP;
            CAPP:    state_d = (k_q == len_q) ? IDLE : RDI;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        ctb_d     = ctb_q;
        case (state_q)
            IDLE: rdy = 1'b1;
            RDL:  ct_addr = 8'd0;
            CAPL: begin
                len_d     = ct_rddata;
                pt_addr   = 8'd0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                i_d       = 8'd0;
                j_d       = 8'd0;
                k_d       = 8'd1;
            end
            RDI: begin
                s_addr  = i_q + 8'd1;
                ct_addr = k_q;
                i_d     = i_q + 8'd1;
            end
            CAPI: begin
                si_d   = s_rddata;
                ctb_d  = ct_rddata;
                s_addr = j_sum;
                j_d    = j_sum;
            end
            CAPJ: begin
                // S[i] <= S[j]; when i==j both writes carry the same byte
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
            end
            WRJ: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
            end
            RDP: s_addr = si_q + sj_q;
            CAPP: begin
                pt_addr   = k_q;
                pt_wrdata = s_rddata ^ ctb_q;
                pt_wren   = 1'b1;
                k_d       = k_q + 8'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Randomised bench for prga: a software RC4 model predicts PT bytes, final S and run length;
// a per-cycle monitor checks every PT write and the exclusive write enables.
module tb_prga;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;

    prga dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories with synchronous read, plus a bench-side load port
    logic [7:0] s_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_q, ct_q;
    logic       ld_s, ld_ct;
    logic [7:0] ld_addr, ld_data;

    always @(posedge clk) begin
        if (ld_s) s_mem[ld_addr] <= ld_data;
        else if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_q <= s_mem[s_addr];
        if (ld_ct) ct_mem[ld_addr] <= ld_data;
        ct_q <= ct_mem[ct_addr];
        if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end
    assign s_rddata  = s_q;
    assign ct_rddata = ct_q;

    int vectors;
    int miscompares;
    int s_wr_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  m_s  [256];
    logic [7:0]  m_ct [256];
    logic [7:0]  m_pt [256];
    logic [15:0] exp_q [$];

    task automatic set_identity();
        for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    endtask

    task automatic set_random_perm();
        logic [7:0] t;
        int r;
        set_identity();
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(0, x);
            t = m_s[x]; m_s[x] = m_s[r]; m_s[r] = t;
        end
    endtask

    task automatic set_ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] j, t, kb;
        set_identity();
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kb = (x % 3 == 0) ? k0 : ((x % 3 == 1) ? k1 : k2);
            j = j + m_s[x] + kb;
            t = m_s[x]; m_s[x] = m_s[j]; m_s[j] = t;
        end
    endtask

    // Plain RC4 PRGA over the model S; i and j restart for every message
    task automatic model_run(input int len);
        logic [7:0] i, j, t;
        m_pt[0] = 8'(len);
        exp_q.push_back({8'd0, m_pt[0]});
        i = 0; j = 0;
        for (int k = 1; k <= len; k++) begin
            i = i + 1;
            j = j + m_s[i];
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            t = m_s[i] + m_s[j];
            m_pt[k] = m_ct[k] ^ m_s[t];
            exp_q.push_back({8'(k), m_pt[k]});
        end
    endtask

    task automatic load_s();
        for (int x = 0; x < 256; x++) begin
            @(negedge clk);
            ld_s = 1'b1; ld_addr = 8'(x); ld_data = m_s[x];
        end
        @(negedge clk);
        ld_s = 1'b0;
    endtask

    task automatic load_ct(input int len);
        for (int x = 0; x <= len; x++) begin
            @(negedge clk);
            ld_ct = 1'b1; ld_addr = 8'(x); ld_data = m_ct[x];
        end
        @(negedge clk);
        ld_ct = 1'b0;
    endtask

    // Monitor: every PT write must be the next predicted (addr,data); never both enables
    always @(negedge clk) begin
        if (!rst) begin
            if (s_wren || pt_wren) check("wren_exclusive", {31'd0, s_wren & pt_wren}, 32'd0);
            if (s_wren) s_wr_cnt++;
            if (pt_wren) begin
                if (exp_q.size() == 0) begin
                    check("pt_unexpected_write", {24'd0, pt_addr}, 32'hFFFF_FFFF);
                end else begin
                    check("pt_addr", {24'd0, pt_addr}, {24'd0, exp_q[0][15:8]});
                    check("pt_data", {24'd0, pt_wrdata}, {24'd0, exp_q[0][7:0]});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One message: S already loaded from m_s, m_ct[0..len] filled
    task automatic run_msg(input int len, input int pulse_at, input int rst_at);
        int cnt, s0, limit;
        logic aborted;
        m_ct[0] = 8'(len);
        exp_q.delete();
        model_run(len);
        load_ct(len);
        s0 = s_wr_cnt;
        @(negedge clk);
        check("rdy_idle", {31'd0, rdy}, 32'd1);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("rdy_drop", {31'd0, rdy}, 32'd0);
        cnt = 0;
        limit = 2 + 6 * len + 20;
        aborted = 1'b0;
        while (cnt < limit) begin
            @(negedge clk);
            cnt++;
            en = (cnt == pulse_at);
            if (cnt == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check("rst_rdy", {31'd0, rdy}, 32'd1);
                check("rst_s_wren", {31'd0, s_wren}, 32'd0);
                check("rst_pt_wren", {31'd0, pt_wren}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                en = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (rdy) break;
        end
        en = 1'b0;
        if (aborted) begin
            exp_q.delete();
        end else begin
            check("latency", cnt, 2 + 6 * len);
            check("pt_writes_left", exp_q.size(), 0);
            check("s_write_count", s_wr_cnt - s0, 2 * len);
            for (int x = 0; x <= len; x++) check("pt_mem", {24'd0, pt_mem[x]}, {24'd0, m_pt[x]});
            for (int x = 0; x < 256; x++) check("s_final", {24'd0, s_mem[x]}, {24'd0, m_s[x]});
        end
    endtask

    task automatic ct_len3();
        m_ct[1] = 8'h00; m_ct[2] = 8'h00; m_ct[3] = 8'h00;
    endtask

    initial begin
        int len;
        vectors = 0; miscompares = 0; s_wr_cnt = 0;
        rst = 1'b1; en = 1'b0; ld_s = 1'b0; ld_ct = 1'b0; ld_addr = 8'd0; ld_data = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_rdy", {31'd0, rdy}, 32'd1);
        check("reset_s_wren", {31'd0, s_wren}, 32'd0);
        check("reset_pt_wren", {31'd0, pt_wren}, 32'd0);
        check("reset_s_addr", {24'd0, s_addr}, 32'd0);
        check("reset_ct_addr", {24'd0, ct_addr}, 32'd0);
        check("reset_pt_addr", {24'd0, pt_addr}, 32'd0);
        rst = 1'b0;

        // Identity S, ct={01,41}
        set_identity(); load_s();
        m_ct[1] = 8'h41;
        run_msg(1, 0, 0);
        check("lit_pt0", {24'd0, pt_mem[0]}, 32'h01);
        check("lit_pt1", {24'd0, pt_mem[1]}, 32'h43);

        // Identity S, ct={03,00,00,00}
        set_identity(); load_s(); ct_len3();
        run_msg(3, 0, 0);
        check("lit3_pt1", {24'd0, pt_mem[1]}, 32'h02);
        check("lit3_pt2", {24'd0, pt_mem[2]}, 32'h05);
        check("lit3_pt3", {24'd0, pt_mem[3]}, 32'h07);
        check("lit3_s2", {24'd0, s_mem[2]}, 32'h03);
        check("lit3_s3", {24'd0, s_mem[3]}, 32'h05);
        check("lit3_s5", {24'd0, s_mem[5]}, 32'h02);

        // Zero-length message
        set_identity(); load_s();
        run_msg(0, 0, 0);
        check("lit0_pt0", {24'd0, pt_mem[0]}, 32'h00);

        // en pulsed while busy
        set_identity(); load_s(); ct_len3();
        run_msg(3, 5, 0);
        check("busy_pt3", {24'd0, pt_mem[3]}, 32'h07);

        // Reset mid-run, then a fresh run on reloaded identity S
        set_identity(); load_s(); ct_len3();
        run_msg(3, 0, 9);
        set_identity(); load_s(); ct_len3();
        run_msg(3, 0, 0);
        check("rerun_pt1", {24'd0, pt_mem[1]}, 32'h02);
        check("rerun_pt2", {24'd0, pt_mem[2]}, 32'h05);
        check("rerun_pt3", {24'd0, pt_mem[3]}, 32'h07);

        // S permuted by KSA with key 00033C, known ciphertext
        set_ksa(8'h00, 8'h03, 8'h3C); load_s();
        for (int x = 1; x <= 32; x++) m_ct[x] = 8'(x * 37 + 11);
        run_msg(32, 0, 0);

        // Random messages; S carries over between runs unless reloaded
        for (int r = 0; r < 12; r++) begin
            if (r % 3 == 0) begin
                set_random_perm(); load_s();
            end
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 255));
            for (int x = 1; x <= len; x++) m_ct[x] = 8'($urandom);
            run_msg(len, (r == 4) ? 7 : 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
